// File: rtl/dp_bram_arbiter.sv
// dp_bram_arbiter
//   Arbitrates single-word read/write requests from NUM_CLIENTS clients onto
//   the two ports (A, B) of a dual-port BRAM. Round-robin order, up to two
//   grants per cycle, same-address hazards between A and B stall port B.
//   Read data is routed back to the issuing client one cycle after the grant.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_we           per-client request valid / write(1)-read(0)
//   req_addr/req_wdata         per-client address / write data, client i at slice i
//   req_ready                  per-client grant (combinational)
//   rsp_valid/rsp_data         per-client read-return pulse / read data
//   conflict_cnt               saturating count of hazard-stall cycles
//   bram_clk, bram_rst_n       pass-through of clk and rst_n
//   addr_*, data_in_*, we_*, en_*   BRAM port A/B drive
//   data_out_a, data_out_b     BRAM registered read data (1-cycle latency)
module dp_bram_arbiter #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned NUM_CLIENTS = 3
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_CLIENTS-1:0]            req_valid,
   input  logic [NUM_CLIENTS-1:0]            req_we,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_CLIENTS-1:0]            req_ready,
   output logic [NUM_CLIENTS-1:0]            rsp_valid,
   output logic [NUM_CLIENTS*DATA_WIDTH-1:0] rsp_data,
   output logic [15:0]                       conflict_cnt,
   output logic                              bram_clk,
   output logic                              bram_rst_n,
   output logic [ADDR_WIDTH-1:0]             addr_a,
   output logic [ADDR_WIDTH-1:0]             addr_b,
   output logic [DATA_WIDTH-1:0]             data_in_a,
   output logic [DATA_WIDTH-1:0]             data_in_b,
   output logic                              we_a,
   output logic                              we_b,
   output logic                              en_a,
   output logic                              en_b,
   input  logic [DATA_WIDTH-1:0]             data_out_a,
   input  logic [DATA_WIDTH-1:0]             data_out_b
);
   localparam int unsigned IDW = $clog2(NUM_CLIENTS);
   localparam int unsigned PW  = IDW + 1;
   typedef logic [IDW-1:0] id_t;

   logic [ADDR_WIDTH-1:0] c_addr  [NUM_CLIENTS];
   logic [DATA_WIDTH-1:0] c_wdata [NUM_CLIENTS];

   for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
      assign c_addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign c_wdata[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   id_t                           rr_ptr_q, rr_ptr_d;
   logic                          pend_a_q, pend_b_q;
   id_t                           pid_a_q, pid_b_q;
   logic [15:0]                   cnt_q, cnt_d;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0] hold_q, rsp_data_d;

   logic gnt_a, gnt_b, hazard;
   id_t  id_a, id_b;

   function automatic id_t wrap_inc(input id_t x);
      return (32'(x) == NUM_CLIENTS - 1) ? '0 : id_t'(x + 1'b1);
   endfunction

   // Scan from rr_ptr: first valid client takes A; only the very next valid
   // client is considered for B, and a hazard with it leaves B idle.
   always_comb begin : arb_scan
      logic [PW-1:0] pos;
      id_t           idx;
      logic          b_seen;
      gnt_a  = 1'b0;
      gnt_b  = 1'b0;
      hazard = 1'b0;
      id_a   = '0;
      id_b   = '0;
      b_seen = 1'b0;
      pos    = '0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
         pos = {1'b0, rr_ptr_q} + PW'(k);
         if (pos >= PW'(NUM_CLIENTS)) pos = pos - PW'(NUM_CLIENTS);
         idx = pos[IDW-1:0];
         if (rst_n && req_valid[idx]) begin
            if (!gnt_a) begin
               gnt_a = 1'b1;
               id_a  = idx;
            end else if (!b_seen) begin
               b_seen = 1'b1;
               if ((c_addr[idx] == c_addr[id_a]) && (req_we[idx] || req_we[id_a])) begin
                  hazard = 1'b1;
               end else begin
                  gnt_b = 1'b1;
                  id_b  = idx;
               end
            end
         end
      end
   end

   always_comb begin
      if (gnt_b)      rr_ptr_d = wrap_inc(id_b);
      else if (gnt_a) rr_ptr_d = wrap_inc(id_a);
      else            rr_ptr_d = rr_ptr_q;
      cnt_d = (hazard && (cnt_q != '1)) ? cnt_q + 16'd1 : cnt_q;
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         req_ready[i] = (gnt_a && (id_a == id_t'(i))) || (gnt_b && (id_b == id_t'(i)));
      end
   end

   assign en_a      = gnt_a;
   assign we_a      = gnt_a & req_we[id_a];
   assign addr_a    = gnt_a ? c_addr[id_a] : '0;
   assign data_in_a = we_a ? c_wdata[id_a] : '0;
   assign en_b      = gnt_b;
   assign we_b      = gnt_b & req_we[id_b];
   assign addr_b    = gnt_b ? c_addr[id_b] : '0;
   assign data_in_b = we_b ? c_wdata[id_b] : '0;

   assign bram_clk     = clk;
   assign bram_rst_n   = rst_n;
   assign conflict_cnt = cnt_q;

   // BRAM output is already registered, so the returning slice is muxed
   // straight from data_out; hold_q keeps every slice's last value.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         logic sel_a, sel_b;
         sel_a = pend_a_q && (pid_a_q == id_t'(i));
         sel_b = pend_b_q && (pid_b_q == id_t'(i));
         rsp_valid[i] = sel_a | sel_b;
         if (sel_a)      rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = data_out_a;
         else if (sel_b) rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = data_out_b;
         else            rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = hold_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign rsp_data = rsp_data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         pend_a_q <= 1'b0;
         pend_b_q <= 1'b0;
         pid_a_q  <= '0;
         pid_b_q  <= '0;
         cnt_q    <= '0;
         hold_q   <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         pend_a_q <= gnt_a & ~req_we[id_a];
         pend_b_q <= gnt_b & ~req_we[id_b];
         pid_a_q  <= id_a;
         pid_b_q  <= id_b;
         cnt_q    <= cnt_d;
         hold_q   <= rsp_data_d;
      end
   end
endmodule

// File: tb/tb_dp_bram_arbiter.sv
module tb_dp_bram_arbiter;
   localparam int DW = 16;
   localparam int AW = 10;
   localparam int NC = 3;

   logic              clk, rst_n;
   logic [NC-1:0]     req_valid, req_we, req_ready, rsp_valid;
   logic [NC*AW-1:0]  req_addr;
   logic [NC*DW-1:0]  req_wdata, rsp_data;
   logic [15:0]       conflict_cnt;
   logic              bram_clk, bram_rst_n;
   logic [AW-1:0]     addr_a, addr_b;
   logic [DW-1:0]     data_in_a, data_in_b, data_out_a, data_out_b;
   logic              we_a, we_b, en_a, en_b;

   dp_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CLIENTS(NC)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .conflict_cnt(conflict_cnt),
      .bram_clk(bram_clk), .bram_rst_n(bram_rst_n), .addr_a(addr_a), .addr_b(addr_b),
      .data_in_a(data_in_a), .data_in_b(data_in_b), .we_a(we_a), .we_b(we_b),
      .en_a(en_a), .en_b(en_b), .data_out_a(data_out_a), .data_out_b(data_out_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural dual-port BRAM, registered read, clocked by bram_clk.
   logic [DW-1:0] mem [1024];
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[10'h005] <= 16'hBEEF;
      mem[10'h020] <= 16'hA5A5;
      data_out_a   <= '0;
      data_out_b   <= '0;
   end
   always @(posedge bram_clk) begin
      if (en_a) begin
         if (we_a) mem[addr_a] <= data_in_a;
         else      data_out_a  <= mem[addr_a];
      end
      if (en_b) begin
         if (we_b) mem[addr_b] <= data_in_b;
         else      data_out_b  <= mem[addr_b];
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   typedef struct {
      logic [2:0]  v, we;
      logic [9:0]  a0, a1, a2;
      logic [15:0] d0, d1, d2;
      logic [2:0]  rdy;
      logic        ena; logic [9:0] aa; logic wea; logic [15:0] dia;
      logic        enb; logic [9:0] ab; logic web; logic [15:0] dib;
      logic [2:0]  rspv;
      logic [15:0] r0, r1, r2;
      logic [15:0] cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic [2:0] v, we, input logic [9:0] a0, a1, a2,
                      input logic [15:0] d0, d1, d2, input logic [2:0] rdy,
                      input logic ena, input logic [9:0] aa, input logic wea, input logic [15:0] dia,
                      input logic enb, input logic [9:0] ab, input logic web, input logic [15:0] dib,
                      input logic [2:0] rspv, input logic [15:0] r0, r1, r2, cnt);
      vec_t t;
      t.v = v; t.we = we; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.d0 = d0; t.d1 = d1; t.d2 = d2;
      t.rdy = rdy; t.ena = ena; t.aa = aa; t.wea = wea; t.dia = dia;
      t.enb = enb; t.ab = ab; t.web = web; t.dib = dib;
      t.rspv = rspv; t.r0 = r0; t.r1 = r1; t.r2 = r2; t.cnt = cnt;
      tbl.push_back(t);
   endtask

   task automatic drive(input logic [2:0] v, we, input logic [9:0] a0, a1, a2,
                        input logic [15:0] d0, d1, d2);
      req_valid = v;
      req_we    = we;
      req_addr  = {a2, a1, a0};
      req_wdata = {d2, d1, d0};
   endtask

   initial begin
      // v    we    a0     a1     a2     d0       d1  d2       rdy  A: en addr we din          B: en addr we din         rspv  r0       r1       r2       cnt
      add(3'b010, 3'b000, 10'h000, 10'h005, 10'h000, 16'h0000, 0, 16'h0000, 3'b010, 1, 10'h005, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);
      add(3'b101, 3'b000, 10'h040, 10'h000, 10'h041, 16'h0000, 0, 16'h0000, 3'b101, 1, 10'h041, 0, 16'h0000, 1, 10'h040, 0, 16'h0000, 3'b010, 16'h0000, 16'hBEEF, 16'h0000, 0);
      add(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 16'h0000, 0, 16'h0000, 3'b000, 0, 10'h000, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b101, 16'h1040, 16'hBEEF, 16'h1041, 0);
      add(3'b100, 3'b000, 10'h000, 10'h000, 10'h052, 16'h0000, 0, 16'h0000, 3'b100, 1, 10'h052, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b000, 16'h1040, 16'hBEEF, 16'h1041, 0);
      add(3'b111, 3'b000, 10'h050, 10'h051, 10'h052, 16'h0000, 0, 16'h0000, 3'b011, 1, 10'h050, 0, 16'h0000, 1, 10'h051, 0, 16'h0000, 3'b100, 16'h1040, 16'hBEEF, 16'h1052, 0);
      add(3'b111, 3'b000, 10'h050, 10'h051, 10'h052, 16'h0000, 0, 16'h0000, 3'b101, 1, 10'h052, 0, 16'h0000, 1, 10'h050, 0, 16'h0000, 3'b011, 16'h1050, 16'h1051, 16'h1052, 0);
      add(3'b100, 3'b000, 10'h000, 10'h000, 10'h060, 16'h0000, 0, 16'h0000, 3'b100, 1, 10'h060, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b101, 16'h1050, 16'h1051, 16'h1052, 0);
      add(3'b011, 3'b001, 10'h010, 10'h010, 10'h000, 16'h1234, 0, 16'h0000, 3'b001, 1, 10'h010, 1, 16'h1234, 0, 10'h000, 0, 16'h0000, 3'b100, 16'h1050, 16'h1051, 16'h1060, 0);
      add(3'b010, 3'b000, 10'h000, 10'h010, 10'h000, 16'h0000, 0, 16'h0000, 3'b010, 1, 10'h010, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b000, 16'h1050, 16'h1051, 16'h1060, 1);
      add(3'b011, 3'b000, 10'h020, 10'h020, 10'h000, 16'h0000, 0, 16'h0000, 3'b011, 1, 10'h020, 0, 16'h0000, 1, 10'h020, 0, 16'h0000, 3'b010, 16'h1050, 16'h1234, 16'h1060, 1);
      add(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 16'h0000, 0, 16'h0000, 3'b000, 0, 10'h000, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b011, 16'hA5A5, 16'hA5A5, 16'h1060, 1);
      add(3'b110, 3'b100, 10'h000, 10'h030, 10'h030, 16'h0000, 0, 16'h7777, 3'b100, 1, 10'h030, 1, 16'h7777, 0, 10'h000, 0, 16'h0000, 3'b000, 16'hA5A5, 16'hA5A5, 16'h1060, 1);
      add(3'b010, 3'b000, 10'h000, 10'h030, 10'h000, 16'h0000, 0, 16'h0000, 3'b010, 1, 10'h030, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b000, 16'hA5A5, 16'hA5A5, 16'h1060, 2);
      add(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 16'h0000, 0, 16'h0000, 3'b000, 0, 10'h000, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b010, 16'hA5A5, 16'h7777, 16'h1060, 2);
      add(3'b101, 3'b101, 10'h070, 10'h000, 10'h071, 16'hCAFE, 0, 16'hF00D, 3'b101, 1, 10'h071, 1, 16'hF00D, 1, 10'h070, 1, 16'hCAFE, 3'b000, 16'hA5A5, 16'h7777, 16'h1060, 2);
      add(3'b001, 3'b000, 10'h070, 10'h000, 10'h000, 16'h0000, 0, 16'h0000, 3'b001, 1, 10'h070, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b000, 16'hA5A5, 16'h7777, 16'h1060, 2);
      add(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 16'h0000, 0, 16'h0000, 3'b000, 0, 10'h000, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 3'b001, 16'hCAFE, 16'h7777, 16'h1060, 2);

      // Reset state with all clients requesting.
      rst_n = 1'b0;
      drive(3'b111, 3'b000, 10'h001, 10'h002, 10'h003, 0, 0, 0);
      #2;
      check("rst_ready", 64'(req_ready), 64'(3'b000));
      check("rst_en", 64'({en_a, en_b, we_a, we_b}), 64'(4'b0000));
      check("rst_rspv", 64'(rsp_valid), 64'(3'b000));
      check("rst_rspd", 64'(rsp_data), 64'(0));
      check("rst_cnt", 64'(conflict_cnt), 64'(0));
      check("rst_bram_rst", 64'(bram_rst_n), 64'(0));
      @(negedge clk);
      drive(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #1;
      check("clk_pass", 64'(bram_clk), 64'(clk));

      foreach (tbl[k]) begin
         @(negedge clk);
         drive(tbl[k].v, tbl[k].we, tbl[k].a0, tbl[k].a1, tbl[k].a2, tbl[k].d0, tbl[k].d1, tbl[k].d2);
         #2;
         check($sformatf("v%0d_ready", k), 64'(req_ready), 64'(tbl[k].rdy));
         check($sformatf("v%0d_en_a", k), 64'(en_a), 64'(tbl[k].ena));
         check($sformatf("v%0d_addr_a", k), 64'(addr_a), 64'(tbl[k].aa));
         check($sformatf("v%0d_we_a", k), 64'(we_a), 64'(tbl[k].wea));
         check($sformatf("v%0d_din_a", k), 64'(data_in_a), 64'(tbl[k].dia));
         check($sformatf("v%0d_en_b", k), 64'(en_b), 64'(tbl[k].enb));
         check($sformatf("v%0d_addr_b", k), 64'(addr_b), 64'(tbl[k].ab));
         check($sformatf("v%0d_we_b", k), 64'(we_b), 64'(tbl[k].web));
         check($sformatf("v%0d_din_b", k), 64'(data_in_b), 64'(tbl[k].dib));
         check($sformatf("v%0d_rspv", k), 64'(rsp_valid), 64'(tbl[k].rspv));
         check($sformatf("v%0d_rspd", k), 64'(rsp_data), 64'({tbl[k].r2, tbl[k].r1, tbl[k].r0}));
         check($sformatf("v%0d_cnt", k), 64'(conflict_cnt), 64'(tbl[k].cnt));
      end

      // Reset while a read is in flight: the response must be dropped.
      @(negedge clk);
      drive(3'b010, 3'b000, 0, 10'h005, 0, 0, 0, 0);
      #2;
      check("mr_grant", 64'(req_ready), 64'(3'b010));
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mr_rspv", 64'(rsp_valid), 64'(3'b000));
      check("mr_en", 64'({en_a, en_b, we_a, we_b}), 64'(4'b0000));
      check("mr_ready", 64'(req_ready), 64'(3'b000));
      check("mr_cnt", 64'(conflict_cnt), 64'(0));
      check("mr_rspd", 64'(rsp_data), 64'(0));
      @(posedge clk);
      #1;
      check("mr_rspv2", 64'(rsp_valid), 64'(3'b000));
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check("post_rst_grant", 64'(req_ready), 64'(3'b010));
      check("post_rst_addr", 64'(addr_a), 64'(10'h005));
      @(negedge clk);
      drive(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
      #2;
      check("post_rst_rspv", 64'(rsp_valid), 64'(3'b010));
      check("post_rst_rspd", 64'(rsp_data[31:16]), 64'(16'hBEEF));

      // Continuous hazard: every cycle stalls port B, counter saturates.
      @(negedge clk);
      drive(3'b011, 3'b001, 10'h100, 10'h100, 0, 16'h5555, 0, 0);
      #2;
      check("sat_hazard_ready", 64'(req_ready), 64'(3'b001));
      check("sat_hazard_en_b", 64'(en_b), 64'(0));
      repeat (1000) @(posedge clk);
      @(negedge clk); #2;
      check("sat_cnt_1000", 64'(conflict_cnt), 64'(16'd1000));
      repeat (64534) @(posedge clk);
      @(negedge clk); #2;
      check("sat_cnt_fffe", 64'(conflict_cnt), 64'(16'hFFFE));
      repeat (6) @(posedge clk);
      @(negedge clk); #2;
      check("sat_cnt_ffff", 64'(conflict_cnt), 64'(16'hFFFF));
      drive(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dp_bram_arbiter.md
# dp_bram_arbiter

Arbiter end of the dual-port BRAM protocol for the convolution datapath. Accepts single-word read/write requests from NUM_CLIENTS convolution-side clients, grants up to two per cycle onto BRAM ports A and B with round-robin fairness, and blocks same-address hazards between the two ports. It drives clock, reset, address, data, enable and write-enable of the BRAM, and routes read data back to the issuing client one cycle later.

## Interface
- DATA_WIDTH, 16, BRAM word width
- ADDR_WIDTH, 10, BRAM address width
- NUM_CLIENTS, 3, number of requesters; legal range 2..8
- clk  input  1  clock; one clock for the whole block
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NUM_CLIENTS  per-client request valid
- req_we  input  NUM_CLIENTS  per-client write (1) / read (0)
- req_addr  input  NUM_CLIENTS*ADDR_WIDTH  per-client address, client i at slice i
- req_wdata  input  NUM_CLIENTS*DATA_WIDTH  per-client write data
- req_ready  output  NUM_CLIENTS  per-client grant, combinational
- rsp_valid  output  NUM_CLIENTS  per-client read-data valid pulse
- rsp_data  output  NUM_CLIENTS*DATA_WIDTH  per-client read data
- conflict_cnt  output  16  saturating count of hazard-stall cycles
- bram_clk, bram_rst_n  output  1 each  copies of clk and rst_n to the BRAM
- addr_a, addr_b  output  ADDR_WIDTH  port addresses
- data_in_a, data_in_b  output  DATA_WIDTH  port write data
- we_a, we_b, en_a, en_b  output  1 each  port write enables and port enables
- data_out_a, data_out_b  input  DATA_WIDTH  BRAM read data, registered, 1-cycle latency

## Operation
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high. The client holds req_we, req_addr and req_wdata stable until the transfer. req_ready[i] is never high without req_valid[i].
- Arbitration order: clients scanned i = rr_ptr, rr_ptr+1, ... mod NUM_CLIENTS.
  - First valid client is granted port A.
  - Next valid client is granted port B, unless a hazard applies.
- Hazard: the port-B candidate's address equals the port-A grantee's address and either request is a write. In that case:
  - Port B stays idle this cycle (the scan does not continue to later clients).
  - conflict_cnt increments, saturating at 0xFFFF.
- Granted port: en=1, we=req_we, addr and data_in taken from the client. For reads, data_in=0.
- Idle port: en=0, we=0, addr=0, data_in=0.
- Round-robin update: rr_ptr <= (last granted client index + 1) mod NUM_CLIENTS. If no grant this cycle, rr_ptr is unchanged.
- Read return: each port has a pipeline stage {pend, client_id}.
  - On the next clk, rsp_valid[client_id] pulses for one cycle.
  - rsp_data slice = data_out of that port.
  - Other slices of rsp_data hold their last value.
- Writes produce no response.
- A client may issue back-to-back requests every cycle.
- Both ports can return data in the same cycle, always to different clients.

## Timing
- Grant and BRAM drive happen in the same cycle as req_valid (combinational). The BRAM samples on the clk rising edge.
- Read data: rsp_valid at cycle T+1 for a grant at cycle T.
- bram_clk = clk and bram_rst_n = rst_n, combinational pass-through.
- Reset asserted (asynchronous):
  - rr_ptr=0, pipeline pend=0, rsp_valid=0, rsp_data=0, conflict_cnt=0.
  - While rst_n is low, req_ready=0 and en_a/en_b/we_a/we_b=0.
- Reset asserted mid-read: the pending response is discarded; no rsp_valid after reset release.
- First grant is possible in the first cycle with rst_n high.

## Test plan
- Single read: client 1 reads addr 0x005 (BRAM holds 0xBEEF), other clients idle -> req_ready[1] same cycle, en_a=1, addr_a=0x005, we_a=0; next cycle rsp_valid[1]=1, rsp_data[1]=0xBEEF; rr_ptr=2.
- Round-robin: rr_ptr=0, clients 0, 1, 2 all read distinct addresses and stay valid -> cycle 0 grants 0→A and 1→B, client 2 stalls; cycle 1 grants 2→A and 0→B; rr_ptr sequence 0, 2, 1.
- Write/read hazard: client 0 writes 0x1234 to 0x010 while client 1 reads 0x010 -> only client 0 granted, conflict_cnt=1; next cycle client 1 granted; the read returns 0x1234.
- Read/read same address: clients 0 and 1 both read 0x020 -> both granted, no conflict count; both rsp_valid pulse together with equal data.
- Reset mid-read: grant a read at cycle T, assert rst_n low before T+1 -> rsp_valid stays 0, all enables 0, conflict_cnt=0; after release, a new read completes normally.
- Saturation: force 65 540 hazard cycles -> conflict_cnt holds at 0xFFFF.
